// File: rtl/scope_pkg.sv
// Shared types and default sizes for the scope capture path.
// No logic; no latency.
// No flow control.
package scope_pkg;

    localparam int SAMPLE_BITS = 14;
    localparam int N_CH        = 2;
    localparam int DEPTH       = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_t;

endpackage

// File: rtl/sample_capture_buf_if.sv
// Control, sample-input and readout signals of the capture buffer.
// No logic; no latency.
// Samples are qualified by sample_valid only; there is no backpressure.
interface sample_capture_buf_if #(
    parameter int BIT_WIDTH = scope_pkg::SAMPLE_BITS,
    parameter int N_CH      = scope_pkg::N_CH,
    parameter int DEPTH     = scope_pkg::DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int W      = N_CH * BIT_WIDTH;

    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] pre_len;
    logic [W-1:0]      sample_in;
    logic              sample_valid;
    logic              trig;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              rd_valid;
    logic [2:0]        state;
    logic              done;
    logic [ADDR_W-1:0] trig_ptr;

    modport master (
        output arm, abort, pre_len, sample_in, sample_valid, trig, rd_en, rd_addr,
        input  rd_data, rd_valid, state, done, trig_ptr
    );

    modport slave (
        input  arm, abort, pre_len, sample_in, sample_valid, trig, rd_en, rd_addr,
        output rd_data, rd_valid, state, done, trig_ptr
    );
endinterface

// File: rtl/sample_ram_dp.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read latency 1 cycle; rdata holds when re is low.
// No backpressure; one write and one read per cycle.
module sample_ram_dp #(
    parameter int W     = 28,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset so the readout starts at a known zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sample_capture_buf.sv
// Armed/triggered circular capture of N_CH channels with pre-trigger history.
// Read latency 1 cycle (rd_en -> rd_data/rd_valid); state changes on the deciding write edge.
// No backpressure: every sample_valid cycle is taken while capturing; reads only served in DONE.
module sample_capture_buf #(
    parameter int BIT_WIDTH = scope_pkg::SAMPLE_BITS,
    parameter int N_CH      = scope_pkg::N_CH,
    parameter int DEPTH     = scope_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    sample_capture_buf_if.slave bus
);
    import scope_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int W      = N_CH * BIT_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic              done_q, rd_valid_q;
    logic              we;

    logic [ADDR_W-1:0] wr_inc, cnt_inc, post_len, rec_start, rd_phys;
    logic              rd_fire;
    logic [W-1:0]      rd_data;

    assign wr_inc    = wr_ptr_q + ADDR_W'(1);
    assign cnt_inc   = cnt_q + ADDR_W'(1);
    assign post_len  = LAST_IDX - pre_q;
    // Oldest stored sample sits pre_q slots before the trigger, modulo DEPTH.
    assign rec_start = trig_ptr_q - pre_q;
    assign rd_phys   = rec_start + bus.rd_addr;
    assign rd_fire   = bus.rd_en && (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        trig_ptr_d = trig_ptr_q;
        we         = 1'b0;
        if (bus.abort) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.arm) begin
                        pre_d    = bus.pre_len;
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                        state_d  = (bus.pre_len == '0) ? ST_ARMED : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.sample_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_inc;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == pre_q) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (bus.sample_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_inc;
                        if (bus.trig) begin
                            trig_ptr_d = wr_ptr_q;
                            cnt_d      = '0;
                            state_d    = (pre_q == LAST_IDX) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (bus.sample_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_inc;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == post_len) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            trig_ptr_q <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            trig_ptr_q <= trig_ptr_d;
            done_q     <= (state_d == ST_DONE) && (state_q != ST_DONE);
            rd_valid_q <= rd_fire;
        end
    end

    sample_ram_dp #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (bus.sample_in),
        .re    (rd_fire),
        .raddr (rd_phys),
        .rdata (rd_data)
    );

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid_q;
    assign bus.state    = state_q;
    assign bus.done     = done_q;
    assign bus.trig_ptr = trig_ptr_q;
endmodule
